// File: rtl/cam_sensor_emu_pkg.sv
// rtl/cam_sensor_emu_pkg.sv - shared types and pixel pattern function for the camera sensor emulator
package cam_sensor_emu_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    F_SETUP,
    LINE,
    HBLANK,
    VBLANK
  } state_t;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_CONST = 2'd3
  } pattern_t;

  function automatic logic [PIX_W-1:0] pix_value(
    input pattern_t         pat,
    input logic [PIX_W-1:0] x,
    input logic [PIX_W-1:0] y,
    input logic [PIX_W-1:0] cval
  );
    case (pat)
      PAT_HRAMP: return x;
      PAT_VRAMP: return y;
      PAT_CHECK: return (x[3] ^ y[3]) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      default:   return cval;
    endcase
  endfunction

endpackage

// File: rtl/cam_sensor_emu_clkdiv.sv
// rtl/cam_sensor_emu_clkdiv.sv - free-running divider producing the pixel clock and the pixel tick
module cam_sensor_emu_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixelclk,
  output logic tick
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pclk_q, pclk_d;

  // pclk follows the next count so its falling edge lands on the tick edge
  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    pclk_d    = (div_cnt_d >= HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pclk_q    <= pclk_d;
    end
  end

  assign tick     = (div_cnt_q == LAST);
  assign pixelclk = pclk_q;

endmodule

// File: rtl/cam_sensor_emu.sv
// rtl/cam_sensor_emu.sv - camera sensor emulator: frame timing FSM and test pattern source
// Define CAM_SENSOR_EMU_STAMP_EN to replace pixel (0,0) with the frame count sampled at frame start.
module cam_sensor_emu
  import cam_sensor_emu_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 8,
  parameter int CLK_DIV  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  input  logic [PIX_W-1:0] const_value,
  input  logic             cam_reset_n,
  output logic             cam_pixelclk,
  output logic [PIX_W-1:0] cam_data,
  output logic             cam_lvalid,
  output logic             cam_fvalid,
  output logic [15:0]      frame_count,
  output logic             busy
);
  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

  logic tick;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  pattern_t         pat_q, pat_d;
  logic [PIX_W-1:0] cval_q, cval_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             lvalid_q, lvalid_d;
  logic             fvalid_q, fvalid_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             launch;
`ifdef CAM_SENSOR_EMU_STAMP_EN
  logic [PIX_W-1:0] stamp_q, stamp_d;
`endif

  cam_sensor_emu_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk      (clk),
    .rst_n    (reset_n),
    .pixelclk (cam_pixelclk),
    .tick     (tick)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    bcnt_d   = bcnt_q;
    pat_d    = pat_q;
    cval_d   = cval_q;
    data_d   = data_q;
    lvalid_d = lvalid_q;
    fvalid_d = fvalid_q;
    fcnt_d   = fcnt_q;
    launch   = 1'b0;
`ifdef CAM_SENSOR_EMU_STAMP_EN
    stamp_d  = stamp_q;
`endif

    // sensor reset wins immediately, independent of the pixel tick
    if (!cam_reset_n) begin
      state_d  = IDLE;
      x_d      = '0;
      y_d      = '0;
      bcnt_d   = '0;
      data_d   = '0;
      lvalid_d = 1'b0;
      fvalid_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        IDLE: launch = enable;
        F_SETUP: begin
          if (bcnt_q == HB_LAST) begin
            state_d  = LINE;
            x_d      = '0;
            y_d      = '0;
            lvalid_d = 1'b1;
`ifdef CAM_SENSOR_EMU_STAMP_EN
            data_d   = stamp_q;
`else
            data_d   = pix_value(pat_q, '0, '0, cval_q);
`endif
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        LINE: begin
          if (x_q == X_LAST) begin
            state_d  = HBLANK;
            bcnt_d   = '0;
            lvalid_d = 1'b0;
            data_d   = '0;
          end else begin
            x_d    = x_q + 1'b1;
            data_d = pix_value(pat_q, PIX_W'(x_d), PIX_W'(y_q), cval_q);
          end
        end
        HBLANK: begin
          if (bcnt_q != HB_LAST) begin
            bcnt_d = bcnt_q + 1'b1;
          end else if (y_q < Y_LAST) begin
            state_d  = LINE;
            x_d      = '0;
            y_d      = y_q + 1'b1;
            lvalid_d = 1'b1;
            data_d   = pix_value(pat_q, '0, PIX_W'(y_d), cval_q);
          end else begin
            state_d  = VBLANK;
            bcnt_d   = '0;
            fvalid_d = 1'b0;
            fcnt_d   = fcnt_q + 16'd1;
          end
        end
        VBLANK: begin
          if (bcnt_q == VB_LAST) begin
            state_d = IDLE;
            launch  = enable;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (launch) begin
        state_d  = F_SETUP;
        bcnt_d   = '0;
        y_d      = '0;
        pat_d    = pattern_t'(pattern_sel);
        cval_d   = const_value;
        fvalid_d = 1'b1;
`ifdef CAM_SENSOR_EMU_STAMP_EN
        stamp_d  = fcnt_q[PIX_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      bcnt_q   <= '0;
      pat_q    <= PAT_HRAMP;
      cval_q   <= '0;
      data_q   <= '0;
      lvalid_q <= 1'b0;
      fvalid_q <= 1'b0;
      fcnt_q   <= '0;
`ifdef CAM_SENSOR_EMU_STAMP_EN
      stamp_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bcnt_q   <= bcnt_d;
      pat_q    <= pat_d;
      cval_q   <= cval_d;
      data_q   <= data_d;
      lvalid_q <= lvalid_d;
      fvalid_q <= fvalid_d;
      fcnt_q   <= fcnt_d;
`ifdef CAM_SENSOR_EMU_STAMP_EN
      stamp_q  <= stamp_d;
`endif
    end
  end

  assign cam_data    = data_q;
  assign cam_lvalid  = lvalid_q;
  assign cam_fvalid  = fvalid_q;
  assign frame_count = fcnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cam_sensor_emu.sv
// tb/tb_cam_sensor_emu.sv - scoreboard bench for cam_sensor_emu with small frame geometry
module tb_cam_sensor_emu;
  localparam int HA = 16;
  localparam int VA = 2;
  localparam int HB = 2;
  localparam int VB = 3;
  localparam int CD = 2;
  localparam int FRAME_TICKS = HB + VA * (HA + HB);
`ifdef CAM_SENSOR_EMU_STAMP_EN
  localparam bit STAMP = 1'b1;
`else
  localparam bit STAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] const_value = 12'd0;
  logic        cam_reset_n = 1'b1;
  logic        cam_pixelclk;
  logic [11:0] cam_data;
  logic        cam_lvalid;
  logic        cam_fvalid;
  logic [15:0] frame_count;
  logic        busy;

  cam_sensor_emu #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .V_BLANK  (VB),
    .CLK_DIV  (CD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pattern_sel  (pattern_sel),
    .const_value  (const_value),
    .cam_reset_n  (cam_reset_n),
    .cam_pixelclk (cam_pixelclk),
    .cam_data     (cam_data),
    .cam_lvalid   (cam_lvalid),
    .cam_fvalid   (cam_fvalid),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int fc;
  } frame_exp_t;

  logic [11:0] exp_pix[$];
  frame_exp_t  exp_frame[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_pix(input int pat, input int x, input int y, input logic [11:0] c);
    if (pat == 0) return 12'(x);
    if (pat == 1) return 12'(y);
    if (pat == 2) return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
    return c;
  endfunction

  task automatic push_frame(input int pat, input logic [11:0] c, input int stamp, input int len, input int fc);
    logic [11:0] p;
    frame_exp_t  fe;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        p = model_pix(pat, x, y, c);
        if (STAMP && x == 0 && y == 0) p = 12'(stamp);
        exp_pix.push_back(p);
      end
    end
    fe.len = len;
    fe.fc  = fc;
    exp_frame.push_back(fe);
  endtask

  task automatic wait_lvalid();
    int n = 0;
    while (!cam_lvalid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_lvalid", cam_lvalid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_fc(input int v);
    int n = 0;
    while (frame_count != 16'(v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frame_count", frame_count, v);
  endtask

  task automatic run_single(input int pat, input logic [11:0] c, input int stamp, input int fc);
    pattern_sel = 2'(pat);
    const_value = c;
    push_frame(pat, c, stamp, FRAME_TICKS, fc);
    enable = 1'b1;
    wait_lvalid();
    enable      = 1'b0;
    pattern_sel = 2'(pat + 1);
    const_value = 12'h123;
    wait_idle();
    chk("frame_count_after_single", frame_count, fc);
  endtask

  // monitor: one sample per pixel period, while pixelclk is high
  initial begin
    int llen = 0;
    int gap = 0;
    int flen = 0;
    logic pl = 1'b0;
    logic pf = 1'b0;
    frame_exp_t fe;
    forever begin
      @(negedge clk);
      if (cam_pixelclk === 1'b1) begin
        if (cam_fvalid && !pf) begin
          flen = 0;
          gap  = 0;
        end
        if (cam_fvalid) flen++;
        if (cam_lvalid && !pl) begin
          chk("hblank_gap", gap, HB);
          llen = 0;
          gap  = 0;
        end
        if (cam_lvalid) begin
          llen++;
          chk("pix_queue_empty", exp_pix.size() == 0, 0);
          if (exp_pix.size() > 0) chk("pixel", cam_data, exp_pix.pop_front());
        end else if (cam_fvalid) begin
          gap++;
          chk("blank_data", cam_data, 0);
        end
        if (!cam_lvalid && pl && !(exp_frame.size() > 0 && exp_frame[0].len < 0))
          chk("line_len", llen, HA);
        if (!cam_fvalid && pf) begin
          chk("frame_queue_empty", exp_frame.size() == 0, 0);
          if (exp_frame.size() > 0) begin
            fe = exp_frame.pop_front();
            if (fe.len >= 0) chk("frame_len", flen, fe.len);
            chk("frame_count_at_fall", frame_count, fe.fc);
          end
        end
        pl = cam_lvalid;
        pf = cam_fvalid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vgap;
    bit saw0;
    bit saw1;

    repeat (3) @(negedge clk);
    chk("rst_pixelclk", cam_pixelclk, 0);
    chk("rst_data", cam_data, 0);
    chk("rst_lvalid", cam_lvalid, 0);
    chk("rst_fvalid", cam_fvalid, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);

    // two back-to-back h-ramp frames, enable dropped during line 0 of the second
    pattern_sel = 2'd0;
    push_frame(0, 12'd0, 0, FRAME_TICKS, 1);
    push_frame(0, 12'd0, 1, FRAME_TICKS, 2);
    enable = 1'b1;
    wait_fc(1);
    vgap = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cam_pixelclk) begin
        if (cam_fvalid) break;
        vgap++;
      end
    end
    chk("vblank_ticks", vgap, VB);
    wait_lvalid();
    enable = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("no_restart_fvalid", cam_fvalid, 0);
    chk("no_restart_busy", busy, 0);
    chk("frame_count_after_stop", frame_count, 2);

    run_single(1, 12'd0, 2, 3);
    run_single(2, 12'd0, 3, 4);
    run_single(3, 12'hABC, 4, 5);
    run_single(0, 12'd0, 5, 6);

    // sensor reset during LINE
    pattern_sel = 2'd0;
    push_frame(0, 12'd0, 6, -1, 6);
    enable = 1'b1;
    wait_lvalid();
    repeat (6) @(negedge clk);
    cam_reset_n = 1'b0;
    @(negedge clk);
    chk("camrst_fvalid", cam_fvalid, 0);
    chk("camrst_lvalid", cam_lvalid, 0);
    chk("camrst_data", cam_data, 0);
    chk("camrst_busy", busy, 0);
    chk("camrst_frame_count", frame_count, 6);
    exp_pix.delete();
    saw0 = 1'b0;
    saw1 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (cam_pixelclk) saw1 = 1'b1;
      else saw0 = 1'b1;
    end
    chk("camrst_pclk_toggles", saw0 && saw1, 1);
    chk("camrst_held_idle", busy, 0);
    push_frame(0, 12'd0, 6, FRAME_TICKS, 7);
    cam_reset_n = 1'b1;
    wait_lvalid();
    enable = 1'b0;
    wait_idle();
    chk("frame_count_after_camrst", frame_count, 7);

    // asynchronous reset between clock edges
    push_frame(0, 12'd0, 7, -1, 0);
    enable = 1'b1;
    wait_lvalid();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pixelclk", cam_pixelclk, 0);
    chk("arst_data", cam_data, 0);
    chk("arst_lvalid", cam_lvalid, 0);
    chk("arst_fvalid", cam_fvalid, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_busy", busy, 0);
    enable = 1'b0;
    exp_pix.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("pix_queue_drained", exp_pix.size(), 0);
    chk("frame_queue_drained", exp_frame.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_sensor_emu.md
Name: cam_sensor_emu

Overview:
- Synthesizable camera-sensor emulator; the transmit end of the camera_sensor conduit (cam_data/cam_lvalid/cam_fvalid/cam_pixelclk, cam_reset_n).
- Drives the camera_control receiver in the video interface system, in place of the real 12-bit sensor, for bring-up and regression.
- Generates frames of configurable geometry with selectable test patterns and a derived pixel clock.
- Runs in the FPGA fabric from the system clock.

Parameters:
- H_ACTIVE, 640, active pixels per line (≥1).
- V_ACTIVE, 480, active lines per frame (≥1).
- H_BLANK, 16, pixel ticks with lvalid low before the first line and after every line (≥1).
- V_BLANK, 8, pixel ticks with fvalid low between frames (≥1).
- CLK_DIV, 4, clk cycles per pixel clock period (even, ≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  start/continue frame generation.
- pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checker, 3 constant.
- const_value  in  12  pixel value for pattern 3.
- cam_reset_n  in  1  sensor reset from camera_control; active low.
- cam_pixelclk  out  1  emulated pixel clock, clk/CLK_DIV, 50% duty.
- cam_data  out  12  pixel data.
- cam_lvalid  out  1  line valid.
- cam_fvalid  out  1  frame valid.
- frame_count  out  16  completed frames, wraps at 0xFFFF→0.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset: all outputs 0; div_cnt 0; state IDLE; frame_count 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 continuously, regardless of cam_reset_n or enable.
  - cam_pixelclk is registered: 1 when div_cnt ≥ CLK_DIV/2, else 0.
  - tick = (div_cnt == CLK_DIV-1). The pixelclk falling edge coincides with the tick edge.
  - cam_data, cam_lvalid and cam_fvalid update only on tick edges, so they are stable CLK_DIV/2 clk cycles before each pixelclk rising edge.
- FSM (advances on ticks only):
  - IDLE: outputs low. If enable && cam_reset_n at a tick: latch pattern_sel/const_value, fvalid←1, go F_SETUP.
  - F_SETUP: H_BLANK ticks with lvalid=0, then LINE with x=0, y=0.
  - LINE: lvalid=1 and cam_data=pix(x,y) for H_ACTIVE ticks (x increments), then HBLANK.
  - HBLANK: lvalid=0, cam_data=0 for H_BLANK ticks.
    - If y<V_ACTIVE-1: y++, go LINE.
    - Else: fvalid←0, frame_count++, go VBLANK.
  - VBLANK: V_BLANK ticks with outputs low. Then, if enable && cam_reset_n: re-latch config, fvalid←1, go F_SETUP. Else go IDLE.
- Frame length: fvalid high for exactly H_BLANK + V_ACTIVE·(H_ACTIVE+H_BLANK) ticks.
- pix(x,y), from the latched config, truncated to 12 bits:
  - 0: x
  - 1: y
  - 2: (x[3]^y[3]) ? 0xFFF : 0x000
  - 3: const_value
- enable deasserted mid-frame: the current frame completes, including VBLANK, then IDLE. Config changes mid-frame are ignored.
- cam_reset_n low, any state: on the next clk edge (not tick-gated) state←IDLE and data/lvalid/fvalid←0. frame_count is not incremented and pixelclk keeps toggling. Restart requires cam_reset_n high and a tick.
- Counter widths are $clog2 of their range; counters never exceed their parameter bound.

Optional Feature:
- CAM_SENSOR_EMU_STAMP_EN defined: pixel (0,0) of each frame outputs frame_count[11:0], sampled at the fvalid rise, instead of pix(0,0). All other pixels are unchanged.
- Undefined: pixel (0,0) = pix(0,0), with no stamp logic present.

Decomposition:
- Package cam_sensor_emu_pkg:
  - state enum: IDLE, F_SETUP, LINE, HBLANK, VBLANK.
  - pattern codes: PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_CONST=3.
  - PIX_W=12.
- Sub-module cam_sensor_emu_clkdiv: owns div_cnt, produces registered cam_pixelclk and tick.
- Pattern generation stays inline.

Test Plan:
1. Params H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3, CLK_DIV=2; pattern 0, enable=1. Expect:
   - fvalid high 14 ticks.
   - lvalid high 4 ticks twice, separated by 2 ticks.
   - data 0,1,2,3 per line.
   - frame_count=1 after fvalid falls; fvalid rises again 3 ticks later.
2. Same params, patterns 1/2/3 (const 0xABC). Expect:
   - pattern 1: line 0 data 0, line 1 data 1.
   - pattern 2, with H_ACTIVE=16: x 8..15 on line 0 = 0xFFF, x 0..7 = 0x000.
   - pattern 3: all active pixels 0xABC.
3. Drop enable during line 0. Expect: frame completes (14 fvalid ticks), then VBLANK, busy→0, no new fvalid; frame_count=1.
4. cam_reset_n low during LINE. Expect: one clk later fvalid=lvalid=data=0, frame_count unchanged, pixelclk still toggling; release → new frame starts at x=0,y=0.
5. Async reset_n assert mid-frame between clk edges. Expect: all outputs 0 immediately, no clk edge required.
6. CAM_SENSOR_EMU_STAMP_EN defined, after 5 frames. Expect: pixel (0,0) of frame 6 equals 0x005, other pixels per pattern; undefined build gives pix(0,0).
